// File: rtl/datapath_ctrl.sv
// datapath_ctrl: multi-cycle controller for the register file / ALU / RAM
// datapath. It fetches one instruction word per valid/ready handshake, then
// walks FETCH -> EXEC (-> MEM for loads) -> FETCH. It also owns the program
// counter and the latched ALU flags used by BZ.
//
// Handshake: instr_ready is high only in FETCH while run=1 and reset is
// released. A word transfers on a rising edge where instr_valid and
// instr_ready are both high. instr_valid seen outside FETCH is ignored and the
// word is not consumed.
module datapath_ctrl #(
  parameter int PC_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  input  logic [3:0]      SIGNAL,
  output logic            instr_ready,
  output logic [PC_W-1:0] pc,
  output logic [4:0]      A,
  output logic [4:0]      B,
  output logic [4:0]      regSel,
  output logic [4:0]      FS,
  output logic            CO,
  output logic            wrt,
  output logic            RAMwrt,
  output logic            muxSelect,
  output logic [3:0]      status,
  output logic            halted,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [1:0] CL_ALU   = 2'b00;
  localparam logic [1:0] CL_LOAD  = 2'b01;
  localparam logic [1:0] CL_STORE = 2'b10;
  localparam logic [4:0] FS_BZ    = 5'b00000;
  localparam logic [4:0] FS_HALT  = 5'b11111;
  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t          state, next_state;
  logic [31:0]     instr_q, instr_d;
  logic [PC_W-1:0] pc_d;
  logic [3:0]      status_d;
  logic [1:0]      cls;
  logic [PC_W-1:0] off_sext;

  // Field decode works only from the latched word, so the datapath selects
  // stay stable through EXEC and MEM whatever the instruction bus does.
  assign cls      = instr_q[31:30];
  assign FS       = instr_q[29:25];
  assign regSel   = instr_q[24:20];
  assign A        = instr_q[19:15];
  assign B        = instr_q[14:10];
  assign CO       = instr_q[0];
  assign off_sext = {{(PC_W-10){instr_q[9]}}, instr_q[9:0]};
  assign dbg_state = state;

  // State, latched instruction, pc and flags; reset clears everything at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      instr_q <= 32'd0;
      pc      <= '0;
      status  <= 4'd0;
    end else begin
      state   <= next_state;
      instr_q <= instr_d;
      pc      <= pc_d;
      status  <= status_d;
    end
  end

  // Next-state, pc/flag update and strobe decode from state and instr_q.
  always_comb begin
    next_state  = state;
    instr_d     = instr_q;
    pc_d        = pc;
    status_d    = status;
    instr_ready = 1'b0;
    wrt         = 1'b0;
    RAMwrt      = 1'b0;
    muxSelect   = 1'b0;
    halted      = 1'b0;
    case (state)
      S_FETCH: begin
        instr_ready = run & reset;
        if (instr_valid && run) begin
          instr_d    = instr;
          next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls)
          CL_ALU: begin
            wrt        = 1'b1;
            status_d   = SIGNAL;
            pc_d       = pc + PC_ONE;
            next_state = S_FETCH;
          end
          CL_LOAD: begin
            // ALU result is the RAM address this cycle; write-back is in MEM.
            next_state = S_MEM;
          end
          CL_STORE: begin
            RAMwrt     = 1'b1;
            pc_d       = pc + PC_ONE;
            next_state = S_FETCH;
          end
          default: begin
            if (FS == FS_HALT) begin
              next_state = S_HALT;
            end else begin
              if (FS == FS_BZ && status[0]) pc_d = pc + off_sext;
              else                          pc_d = pc + PC_ONE;
              next_state = S_FETCH;
            end
          end
        endcase
      end
      S_MEM: begin
        wrt        = 1'b1;
        muxSelect  = 1'b1;
        pc_d       = pc + PC_ONE;
        next_state = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        next_state = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed bench for datapath_ctrl: a table of single instructions with
// hand-computed EXEC/MEM outputs and post-instruction pc/status, followed by
// hand-written sequences for stall, halt and asynchronous reset.
module tb_datapath_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        instr_valid;
  logic [31:0] instr;
  logic [3:0]  SIGNAL;
  logic        instr_ready;
  logic [15:0] pc;
  logic [4:0]  A, B, regSel, FS;
  logic        CO, wrt, RAMwrt, muxSelect;
  logic [3:0]  status;
  logic        halted;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  datapath_ctrl #(.PC_W(16)) dut (
    .clk(clk), .reset(reset), .run(run), .instr_valid(instr_valid),
    .instr(instr), .SIGNAL(SIGNAL), .instr_ready(instr_ready), .pc(pc),
    .A(A), .B(B), .regSel(regSel), .FS(FS), .CO(CO), .wrt(wrt),
    .RAMwrt(RAMwrt), .muxSelect(muxSelect), .status(status),
    .halted(halted), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [3:0]  sig;
    logic        load;
    logic [4:0]  ea, eb, ers, efs;
    logic        eco, ewrt, eramwrt;
    logic [15:0] pc_after;
    logic [3:0]  st_after;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [31:0] enc(logic [1:0] cls, logic [4:0] f, logic [4:0] da,
                                      logic [4:0] sa, logic [4:0] sb, logic [9:0] lo);
    return {cls, f, da, sa, sb, lo};
  endfunction

  function automatic vec_t mk(logic [1:0] cls, logic [4:0] f, logic [4:0] da, logic [4:0] sa,
                              logic [4:0] sb, logic [9:0] lo, logic [3:0] sig, logic ew,
                              logic er, logic [15:0] pa, logic [3:0] sa_t);
    vec_t v;
    v.word = enc(cls, f, da, sa, sb, lo);
    v.sig = sig; v.load = (cls == 2'b01);
    v.ea = sa; v.eb = sb; v.ers = da; v.efs = f; v.eco = lo[0];
    v.ewrt = ew; v.eramwrt = er; v.pc_after = pa; v.st_after = sa_t;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_strobes(string tag);
    chk({tag, ".wrt"}, wrt, 1'b0);
    chk({tag, ".RAMwrt"}, RAMwrt, 1'b0);
    chk({tag, ".mux"}, muxSelect, 1'b0);
  endtask

  // Driver: issue one instruction from FETCH and check it to completion.
  task automatic run_vec(int idx, logic [15:0] pc_before);
    vec_t v;
    v = vecs[idx];
    instr = v.word; instr_valid = 1'b1; run = 1'b1; SIGNAL = 4'b1110;
    #1;
    chk($sformatf("v%0d.ready_fetch", idx), instr_ready, 1'b1);
    step();
    // EXEC: garbage on the bus with valid high must not be consumed
    chk($sformatf("v%0d.A", idx), A, v.ea);
    chk($sformatf("v%0d.B", idx), B, v.eb);
    chk($sformatf("v%0d.regSel", idx), regSel, v.ers);
    chk($sformatf("v%0d.FS", idx), FS, v.efs);
    chk($sformatf("v%0d.CO", idx), CO, v.eco);
    chk($sformatf("v%0d.wrt_exec", idx), wrt, v.ewrt);
    chk($sformatf("v%0d.ramwrt_exec", idx), RAMwrt, v.eramwrt);
    chk($sformatf("v%0d.mux_exec", idx), muxSelect, 1'b0);
    chk($sformatf("v%0d.ready_exec", idx), instr_ready, 1'b0);
    chk($sformatf("v%0d.pc_exec", idx), pc, pc_before);
    instr = $urandom; instr_valid = 1'b1; SIGNAL = v.sig; run = 1'b0;
    step();
    SIGNAL = 4'b1110;
    if (v.load) begin
      chk($sformatf("v%0d.wrt_mem", idx), wrt, 1'b1);
      chk($sformatf("v%0d.mux_mem", idx), muxSelect, 1'b1);
      chk($sformatf("v%0d.ramwrt_mem", idx), RAMwrt, 1'b0);
      chk($sformatf("v%0d.A_mem", idx), A, v.ea);
      chk($sformatf("v%0d.regSel_mem", idx), regSel, v.ers);
      chk($sformatf("v%0d.pc_mem", idx), pc, pc_before);
      step();
    end
    run = 1'b1;
    #1;
    chk($sformatf("v%0d.pc_after", idx), pc, v.pc_after);
    chk($sformatf("v%0d.status_after", idx), status, v.st_after);
    chk($sformatf("v%0d.ready_after", idx), instr_ready, 1'b1);
    chk_idle_strobes($sformatf("v%0d.after", idx));
  endtask

  initial begin
    logic [15:0] cur_pc;
    reset = 1'b0; run = 1'b1; instr_valid = 1'b0; instr = 32'd0; SIGNAL = 4'd0;

    //              cls    fs      da     sa     sb     lo       sig      wrt   ramwrt pc_after  st
    vecs[0]  = mk(2'b00, 5'd2,  5'd3,  5'd1,  5'd2,  10'd1,   4'b0001, 1'b1, 1'b0, 16'd1,    4'b0001);
    vecs[1]  = mk(2'b01, 5'd0,  5'd7,  5'd4,  5'd5,  10'd0,   4'b1110, 1'b0, 1'b0, 16'd2,    4'b0001);
    vecs[2]  = mk(2'b10, 5'd1,  5'd0,  5'd6,  5'd8,  10'd1,   4'b1110, 1'b0, 1'b1, 16'd3,    4'b0001);
    vecs[3]  = mk(2'b11, 5'd5,  5'd0,  5'd0,  5'd0,  10'd0,   4'b1110, 1'b0, 1'b0, 16'd4,    4'b0001);
    vecs[4]  = mk(2'b11, 5'd0,  5'd0,  5'd0,  5'd0,  10'd1,   4'b1110, 1'b0, 1'b0, 16'd5,    4'b0001);
    vecs[5]  = mk(2'b11, 5'd0,  5'd0,  5'd0,  5'd0,  10'h3FE, 4'b1110, 1'b0, 1'b0, 16'd3,    4'b0001);
    vecs[6]  = mk(2'b11, 5'd5,  5'd0,  5'd0,  5'd0,  10'd0,   4'b1111, 1'b0, 1'b0, 16'd4,    4'b0001);
    vecs[7]  = mk(2'b00, 5'd1,  5'd9,  5'd10, 5'd11, 10'd0,   4'b1010, 1'b1, 1'b0, 16'd5,    4'b1010);
    vecs[8]  = mk(2'b11, 5'd0,  5'd0,  5'd0,  5'd0,  10'h3FE, 4'b1111, 1'b0, 1'b0, 16'd6,    4'b1010);
    vecs[9]  = mk(2'b00, 5'd4,  5'd1,  5'd1,  5'd1,  10'd0,   4'b0001, 1'b1, 1'b0, 16'd7,    4'b0001);
    vecs[10] = mk(2'b11, 5'd0,  5'd0,  5'd0,  5'd0,  10'h3F9, 4'b1110, 1'b0, 1'b0, 16'd0,    4'b0001);
    vecs[11] = mk(2'b11, 5'd0,  5'd0,  5'd0,  5'd0,  10'h3FF, 4'b1110, 1'b0, 1'b0, 16'hFFFF, 4'b0001);
    vecs[12] = mk(2'b11, 5'd3,  5'd0,  5'd0,  5'd0,  10'd0,   4'b1110, 1'b0, 1'b0, 16'd0,    4'b0001);
    vecs[13] = mk(2'b11, 5'd3,  5'd0,  5'd0,  5'd0,  10'd0,   4'b1110, 1'b0, 1'b0, 16'd1,    4'b0001);

    // reset held for 3 cycles
    #1;
    chk("rst.ready_low", instr_ready, 1'b0);
    step(); step(); step();
    chk("rst.pc", pc, 16'd0);
    chk("rst.halted", halted, 1'b0);
    chk("rst.status", status, 4'd0);
    chk_idle_strobes("rst");
    reset = 1'b1;
    #1;
    chk("rst.ready_after", instr_ready, 1'b1);
    chk("rst.state", dbg_state, 2'd0);

    // table of single instructions
    cur_pc = 16'd0;
    for (int i = 0; i < 14; i++) begin
      run_vec(i, cur_pc);
      cur_pc = vecs[i].pc_after;
    end

    // stall: run=0 with a word offered for 10 cycles
    run = 1'b0; instr_valid = 1'b1; instr = enc(2'b00, 5'd2, 5'd3, 5'd1, 5'd2, 10'd1);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("stall%0d.ready", i), instr_ready, 1'b0);
      chk($sformatf("stall%0d.pc", i), pc, 16'd1);
      step();
    end
    chk("stall.state", dbg_state, 2'd0);

    // HALT: stays halted with valid words offered
    run = 1'b1; instr = enc(2'b11, 5'd31, 5'd0, 5'd0, 5'd0, 10'd0);
    step();
    chk("halt.exec_halted", halted, 1'b0);
    instr = enc(2'b00, 5'd2, 5'd3, 5'd1, 5'd2, 10'd1);
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("halt%0d.halted", i), halted, 1'b1);
      chk($sformatf("halt%0d.ready", i), instr_ready, 1'b0);
      chk($sformatf("halt%0d.pc", i), pc, 16'd1);
      chk($sformatf("halt%0d.wrt", i), wrt, 1'b0);
      step();
    end

    // reset pulse leaves HALT
    #2 reset = 1'b0;
    #1;
    chk("hrst.halted", halted, 1'b0);
    chk("hrst.pc", pc, 16'd0);
    chk("hrst.ready", instr_ready, 1'b0);
    instr_valid = 1'b0;
    step();
    reset = 1'b1;
    #1;
    chk("hrst.state", dbg_state, 2'd0);
    chk("hrst.ready_after", instr_ready, 1'b1);

    // reset during MEM of a LOAD
    instr = enc(2'b01, 5'd0, 5'd7, 5'd4, 5'd5, 10'd0); instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    chk("mrst.wrt_mem", wrt, 1'b1);
    chk("mrst.mux_mem", muxSelect, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("mrst.wrt_drop", wrt, 1'b0);
    chk("mrst.mux_drop", muxSelect, 1'b0);
    chk("mrst.pc", pc, 16'd0);
    chk("mrst.state", dbg_state, 2'd0);
    chk("mrst.regSel", regSel, 5'd0);
    step();
    chk("mrst.pc_next_edge", pc, 16'd0);
    reset = 1'b1;
    #1;
    chk("mrst.ready_after", instr_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
